// File: rtl/serial_pkg.sv
// Shared definitions for the serial receiver: FSM state encoding and
// default frame timing constants.
package serial_pkg;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; both flops
// preset to 1 so that leaving reset looks like an idle line.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_rx.sv
// Serial receiver: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit.
// Start bit is confirmed at mid-bit, then every bit is sampled one bit time apart.
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state;
    rx_state_t            state_next;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 baud_clear;
    logic                 bit_clear;
    logic                 sample_bit;
    logic                 load_word;
    logic                 stop_error;

    sync_2ff u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The baud counter is held at zero outside the timed states, so every
    // timed state starts counting from a fresh sample point.
    always_comb begin
        state_next = state;
        baud_clear = 1'b0;
        bit_clear  = 1'b0;
        sample_bit = 1'b0;
        load_word  = 1'b0;
        stop_error = 1'b0;
        case (state)
            IDLE: begin
                baud_clear = 1'b1;
                if (!rx_s) begin
                    state_next = START;
                    bit_clear  = 1'b1;
                end
            end
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_clear = 1'b1;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == FULL_LAST) begin
                    baud_clear = 1'b1;
                    sample_bit = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_cnt == FULL_LAST) begin
                    baud_clear = 1'b1;
                    if (rx_s) begin
                        load_word  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_error = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                baud_clear = 1'b1;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
        end else if (baud_clear) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (bit_clear) begin
            bit_cnt <= '0;
        end else if (sample_bit) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // LSB arrives first, so shifting right leaves it in bit 0 at the end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift <= '0;
        end else if (sample_bit) begin
            shift <= {rx_s, shift[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            data_valid  <= load_word;
            frame_error <= stop_error;
            if (load_word) begin
                data_out <= shift;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high; ports are named clock and reset.
REQ-002 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal values are even and at least 4.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame; legal range is 5 to 8.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 rx  input  1  asynchronous serial line; idles high.
REQ-007 data_out  output  DATA_BITS  last good received word.
REQ-008 data_valid  output  1  one-cycle pulse marking a new data_out.
REQ-009 frame_error  output  1  one-cycle pulse when the stop bit is low.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; all references to rx below mean rx_s, the synchronized value.
REQ-012 Frame format SHALL be: 1 start bit (0), DATA_BITS data bits sent LSB first, then 1 stop bit (1); there is no parity bit.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-014 IDLE -> START SHALL occur on the first cycle in which rx_s = 0; the bit counter clears in the same cycle.
REQ-015 In START, after CLKS_PER_BIT/2 cycles the block SHALL resample rx_s: if 1, this is a glitch and the FSM returns to IDLE with no pulse; if 0, the FSM goes to DATA.
REQ-016 In DATA, each bit SHALL be sampled exactly CLKS_PER_BIT cycles after the previous sample point, into bit index 0..DATA_BITS-1.
REQ-017 After DATA_BITS samples, the FSM SHALL go to STOP and sample again after CLKS_PER_BIT cycles.
REQ-018 Stop bit = 1: in the next cycle, data_out SHALL load the assembled word, data_valid SHALL pulse for 1 cycle, and the FSM returns to IDLE.
REQ-019 Stop bit = 0: in the next cycle, frame_error SHALL pulse for 1 cycle, data_out SHALL stay unchanged, and the FSM goes to WAIT_HIGH.
REQ-020 WAIT_HIGH SHALL go to IDLE on the first cycle with rx_s = 1; a line held low (break) therefore produces only a single frame_error.
REQ-021 data_valid and frame_error SHALL never be asserted in the same cycle and SHALL never be high for two consecutive cycles.
REQ-022 The baud counter width SHALL be $clog2(CLKS_PER_BIT); it SHALL reload to 0 at each sample point and never wrap mid-bit.
REQ-023 A falling edge on rx while in START, DATA or STOP SHALL NOT restart the frame.
REQ-024 A new start bit detected in the cycle immediately after the STOP->IDLE return SHALL be accepted, so back-to-back frames work.

Reset
REQ-025 Reset SHALL force, immediately and asynchronously: state = IDLE; counters = 0; data_out = 0; data_valid = 0; frame_error = 0; busy = 0.
REQ-026 Reset SHALL preset both synchronizer flops to 1 (idle line) so that release does not fake a start bit.
REQ-027 Reset asserted mid-frame SHALL discard the partial word with no pulse; reception restarts at the next falling edge after release.

Structure
REQ-028 A shared package serial_pkg SHALL hold the state enumeration and the default CLKS_PER_BIT and DATA_BITS constants.
REQ-029 The synchronizer SHALL be a sub-module sync_2ff (clock, reset, d, q; both flops reset to 1), built from two D flip-flops.
REQ-030 All other logic SHALL be in serial_rx as one state register, the baud counter, the bit counter and the shift register.

Verification (CLKS_PER_BIT = 16, DATA_BITS = 8)
REQ-031 Send frame 0xA5 with a good stop bit -> data_valid pulses once, about 153 cycles after the start edge, with data_out = 8'hA5; frame_error stays 0.
REQ-032 Drive a 5-cycle low glitch from idle -> no data_valid, no frame_error; busy returns to 0 within 10 cycles.
REQ-033 Send 0x3C with stop bit = 0, then hold rx low 100 cycles, then release high -> exactly one frame_error pulse; data_out keeps its previous value; IDLE is reached after rx goes high.
REQ-034 Send 0x00, 0xFF, 0x81 back-to-back with no idle gap -> three data_valid pulses in order, with data_out = 00, FF, 81.
REQ-035 Assert reset during data bit 4 of 0x5A, release, then send 0x12 -> no pulse for 0x5A; data_out = 8'h12 after the single valid pulse.
REQ-036 Release reset while rx = 1 -> busy stays 0 and no false start occurs.
